multdiv_controller: RTL and testbench
=====================================

MULTDIV_CONTROLLER -- requirements
Module: multdiv_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ctrl_MULT, input, 1: one-cycle start pulse for a signed multiply.
REQ-005 SHALL have port ctrl_DIV, input, 1: one-cycle start pulse for a signed divide.
REQ-006 SHALL have port data_operandA, input, WIDTH: multiplicand/dividend, sampled only on the start edge.
REQ-007 SHALL have port data_operandB, input, WIDTH: multiplier/divisor, sampled only on the start edge.
REQ-008 SHALL have port data_result, output, WIDTH: product low word or quotient; valid while data_resultRDY=1.
REQ-009 SHALL have port data_exception, output, 1: overflow or divide-by-zero; valid while data_resultRDY=1.
REQ-010 SHALL have port data_resultRDY, output, 1: one-cycle completion strobe.
REQ-011 SHALL have port busy, output, 1: high from the cycle after start until the cycle data_resultRDY is high, inclusive.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-013 Start edge (IDLE or any state): latch operand magnitudes, operand signs and op; clear the iteration count; go to RUN.
REQ-014 RUN: one radix-2 shift-add (MULT) or restoring shift-subtract (DIV) step per cycle for exactly WIDTH cycles, then FIX.
REQ-015 FIX: apply the sign correction and compute the exception in one cycle, then DONE.
REQ-016 DONE: data_resultRDY=1 for exactly one cycle, then IDLE; result is WIDTH+2 cycles after the start edge.
REQ-017 data_result and data_exception SHALL hold their last values in IDLE until the next start.
REQ-018 MULT SHALL set exception when the signed 2*WIDTH product is not representable in WIDTH bits; result is the product's low WIDTH bits.
REQ-019 DIV SHALL truncate toward zero and discard the remainder.
REQ-020 DIV with divisor 0 SHALL give result 0 and exception 1 at the normal latency.
REQ-021 DIV of the most-negative value by -1 SHALL give result 0x80000000 (WIDTH=32) and exception 1.
REQ-022 ctrl_MULT and ctrl_DIV high in the same cycle SHALL be treated as MULT.
REQ-023 A start during RUN/FIX/DONE SHALL abort the current op with no data_resultRDY for it and restart with the new operands.

Reset
REQ-024 reset SHALL force IDLE and zero data_result, data_exception, data_resultRDY, busy and all internal registers on the next edge.
REQ-025 reset SHALL take priority over a simultaneous start; reset mid-op SHALL produce no data_resultRDY.

Configuration
REQ-026 With MULTDIV_DIV_EN defined, divide SHALL be fully supported per REQ-019..021.
REQ-027 Without MULTDIV_DIV_EN, ctrl_DIV alone SHALL go to DONE on the next edge with result 0 and exception 1, and no divide datapath SHALL be synthesized.

Structure
REQ-028 Package multdiv_pkg SHALL hold the state enum typedef, the op typedef (OP_MULT, OP_DIV) and the default-width constant.
REQ-029 The iteration counter SHALL be the sub-module multdiv_iter_counter (clear, enable, terminal-count output at WIDTH-1).

Verification
REQ-030 A=6, B=7, ctrl_MULT pulse -> data_resultRDY exactly 34 cycles later, result 42, exception 0.
REQ-031 A=-3, B=5, MULT -> result 0xFFFFFFF1, exception 0; A=0x00010000, B=0x00010000 -> result 0, exception 1.
REQ-032 A=100, B=-7, DIV -> result 0xFFFFFFF2 (-14), exception 0; A=5, B=0 -> result 0, exception 1.
REQ-033 MULT 6*7 started, new MULT 3*3 on cycle 10 -> a single data_resultRDY 34 cycles after the second pulse, result 9.
REQ-034 reset asserted on cycle 20 of a DIV -> outputs 0 the next cycle, no data_resultRDY within 40 cycles, busy 0.
REQ-035 Build without MULTDIV_DIV_EN, then pulse ctrl_DIV -> data_resultRDY on the next cycle, exception 1, result 0.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM state and op types plus the default operand width
package multdiv_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

   typedef enum logic {OP_MULT, OP_DIV} op_e;

endpackage

// File: rtl/multdiv_iter_counter.sv
// multdiv_iter_counter: iteration counter with clear, enable and terminal count at WIDTH-1
module multdiv_iter_counter
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // clear wins over enable so a restart always begins from zero
   always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;

   // count register
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tc_o = cnt_q == CW'(WIDTH - 1);

endmodule

// File: rtl/multdiv_controller.sv
// multdiv_controller: iterative signed multiply/divide; divide datapath only with MULTDIV_DIV_EN defined
module multdiv_controller
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int PW = 2 * WIDTH + 1;

   state_e           state_q, state_d;
   logic [PW-1:0]    p_q, p_d;
   logic [WIDTH-1:0] m_q, m_d, res_q, res_d;
   logic             sa_q, sa_d, sb_q, sb_d, exc_q, exc_d;
   logic             start, tc;
   logic [WIDTH:0]   mul_sum;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]   prod_hi;
   logic             mul_exc;
`ifdef MULTDIV_DIV_EN
   op_e              op_q, op_d;
   logic [PW-1:0]    div_t;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] quo;
`endif

   assign start = ctrl_MULT | ctrl_DIV;

   multdiv_iter_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk_i (clock),
      .rst_i (reset),
      .clr_i (start),
      .en_i  (state_q == RUN),
      .tc_o  (tc)
   );

   // step and sign-fix arithmetic on the {remainder/high, quotient/low} register
   always_comb begin
      mul_sum = p_q[PW-1:WIDTH] + (p_q[0] ? {1'b0, m_q} : '0);
      prod    = (sa_q ^ sb_q) ? -p_q[2*WIDTH-1:0] : p_q[2*WIDTH-1:0];
      prod_hi = prod[2*WIDTH-1:WIDTH-1];
      mul_exc = ~(&prod_hi | ~|prod_hi);
`ifdef MULTDIV_DIV_EN
      div_t    = {p_q[2*WIDTH-1:0], 1'b0};
      div_diff = div_t[PW-1:WIDTH] - {1'b0, m_q};
      quo      = (sa_q ^ sb_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
`endif
   end

   // next state and datapath updates; a start from any state restarts the op
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      m_d     = m_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      exc_d   = exc_q;
`ifdef MULTDIV_DIV_EN
      op_d    = op_q;
`endif
      if (start) begin
         sa_d = data_operandA[WIDTH-1];
         sb_d = data_operandB[WIDTH-1];
         m_d  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
         p_d  = {{(WIDTH+1){1'b0}}, data_operandA[WIDTH-1] ? -data_operandA : data_operandA};
`ifdef MULTDIV_DIV_EN
         op_d    = ctrl_MULT ? OP_MULT : OP_DIV;
         state_d = RUN;
`else
         state_d = ctrl_MULT ? RUN : DONE;
         res_d   = ctrl_MULT ? res_q : '0;
         exc_d   = ctrl_MULT ? exc_q : 1'b1;
`endif
      end else if (state_q == RUN) begin
`ifdef MULTDIV_DIV_EN
         p_d = (op_q == OP_MULT) ? PW'({mul_sum, p_q[WIDTH-1:0]} >> 1)
             : div_diff[WIDTH] ? div_t : {div_diff, div_t[WIDTH-1:1], 1'b1};
`else
         p_d = PW'({mul_sum, p_q[WIDTH-1:0]} >> 1);
`endif
         state_d = tc ? FIX : RUN;
      end else if (state_q == FIX) begin
`ifdef MULTDIV_DIV_EN
         res_d = (op_q == OP_MULT) ? prod[WIDTH-1:0] : (m_q == '0) ? '0 : quo;
         exc_d = (op_q == OP_MULT) ? mul_exc
               : (m_q == '0) | (~(sa_q ^ sb_q) & p_q[WIDTH-1]);
`else
         res_d = prod[WIDTH-1:0];
         exc_d = mul_exc;
`endif
         state_d = DONE;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   // state and datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         p_q     <= '0;
         m_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         res_q   <= '0;
         exc_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
         op_q    <= OP_MULT;
`endif
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         m_q     <= m_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
`ifdef MULTDIV_DIV_EN
         op_q    <= op_d;
`endif
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = state_q == DONE;
   assign busy           = state_q != IDLE;

endmodule

// File: tb/tb_multdiv_controller.sv
// tb_multdiv_controller: directed checks of multdiv_controller (divide vectors with MULTDIV_DIV_EN)
module tb_multdiv_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int n_tests = 0;
   int n_fail = 0;

   multdiv_controller #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_MULT = m;
      ctrl_DIV = d;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
   endtask

   task automatic wait_rdy(output int lat);
      lat = 1;
      while (!data_resultRDY && lat < 100) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ee);
      int lat;
      start_op(m, d, a, b);
      wait_rdy(lat);
      check({tag, " latency"}, 64'(lat), 64'd34);
      check({tag, " result"}, 64'(data_result), 64'(er));
      check({tag, " exception"}, 64'(data_exception), 64'(ee));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int rdy_seen;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("reset result", 64'(data_result), 64'd0);
      check("reset exception", 64'(data_exception), 64'd0);
      check("reset rdy", 64'(data_resultRDY), 64'd0);
      check("reset busy", 64'(busy), 64'd0);

      start_op(1'b1, 1'b0, 32'd6, 32'd7);
      check("6*7 busy early", 64'(busy), 64'd1);
      wait_rdy(lat);
      check("6*7 latency", 64'(lat), 64'd34);
      check("6*7 result", 64'(data_result), 64'd42);
      check("6*7 exception", 64'(data_exception), 64'd0);
      check("6*7 busy at rdy", 64'(busy), 64'd1);
      @(negedge clock);
      check("6*7 rdy one cycle", 64'(data_resultRDY), 64'd0);
      check("6*7 busy after", 64'(busy), 64'd0);
      check("6*7 result held", 64'(data_result), 64'd42);

      run_op("-3*5", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0);
      run_op("2^16*2^16", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
      run_op("min*-1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("min*1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
      run_op("-1*-1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op("both ctrl", 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0);

`ifdef MULTDIV_DIV_EN
      run_op("100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
      run_op("5/0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
      run_op("min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op("42/6", 1'b0, 1'b1, 32'd42, 32'd6, 32'd7, 1'b0);
`else
      start_op(1'b0, 1'b1, 32'd100, 32'd7);
      wait_rdy(lat);
      check("div off latency", 64'(lat), 64'd1);
      check("div off result", 64'(data_result), 64'd0);
      check("div off exception", 64'(data_exception), 64'd1);
      check("div off busy", 64'(busy), 64'd1);
      @(negedge clock);
      check("div off rdy after", 64'(data_resultRDY), 64'd0);
      run_op("after div off", 1'b1, 1'b0, 32'd4, 32'd5, 32'd20, 1'b0);
`endif

      rdy_seen = 0;
      start_op(1'b1, 1'b0, 32'd6, 32'd7);
      repeat (8) begin
         @(negedge clock);
         if (data_resultRDY) rdy_seen++;
      end
      start_op(1'b1, 1'b0, 32'd3, 32'd3);
      wait_rdy(lat);
      check("abort no early rdy", 64'(rdy_seen), 64'd0);
      check("abort latency", 64'(lat), 64'd34);
      check("abort result", 64'(data_result), 64'd9);

`ifdef MULTDIV_DIV_EN
      start_op(1'b0, 1'b1, 32'd100, 32'd3);
`else
      start_op(1'b1, 1'b0, 32'd100, 32'd3);
`endif
      repeat (19) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midreset result", 64'(data_result), 64'd0);
      check("midreset exception", 64'(data_exception), 64'd0);
      check("midreset busy", 64'(busy), 64'd0);
      rdy_seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY) rdy_seen++;
      end
      check("midreset no rdy", 64'(rdy_seen), 64'd0);
      check("midreset busy later", 64'(busy), 64'd0);

      @(negedge clock);
      reset = 1'b1;
      ctrl_MULT = 1'b1;
      data_operandA = 32'd2;
      data_operandB = 32'd2;
      @(negedge clock);
      reset = 1'b0;
      ctrl_MULT = 1'b0;
      check("reset beats start busy", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
